// File: rtl/series_rom_sequencer.sv
// Horner-rule polynomial evaluator that steps a combinational coefficient ROM.
// Optional build macro SERIES_SAT_EN: saturating reductions plus a sticky ovf output.
module series_rom_sequencer #(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 10,
  parameter int N_TERMS = 7,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  x,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_data,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result
`ifdef SERIES_SAT_EN
  ,
  output logic              ovf
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_TERMS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] x_q;
  logic signed [WIDTH-1:0] term;
  logic signed [WIDTH-1:0] sum;

`ifdef SERIES_SAT_EN
  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [PW-1:0]  shifted;
  logic signed [WIDTH:0] sum_wide;
  logic                  term_ovf;
  logic                  sum_ovf;

  // A reduction overflows when the bits above the kept field are not a pure sign extension.
  always_comb begin
    shifted  = (PW'(acc) * PW'(x_q)) >>> FRAC;
    term_ovf = (|shifted[PW-1:WIDTH-1]) && !(&shifted[PW-1:WIDTH-1]);
    term     = term_ovf ? (shifted[PW-1] ? SAT_MIN : SAT_MAX) : shifted[WIDTH-1:0];
    sum_wide = (WIDTH+1)'(term) + (WIDTH+1)'($signed(rom_data));
    sum_ovf  = sum_wide[WIDTH] != sum_wide[WIDTH-1];
    sum      = sum_ovf ? (sum_wide[WIDTH] ? SAT_MIN : SAT_MAX) : sum_wide[WIDTH-1:0];
  end
`else
  // Operands are widened before multiplying so the full product survives the shift.
  always_comb begin
    term = WIDTH'((PW'(acc) * PW'(x_q)) >>> FRAC);
    sum  = term + $signed(rom_data);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ITER;
      ITER:    if (rom_addr == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      x_q      <= '0;
      rom_addr <= '0;
      result   <= '0;
`ifdef SERIES_SAT_EN
      ovf      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_q      <= x;
            acc      <= '0;
            rom_addr <= LAST_ADDR;
`ifdef SERIES_SAT_EN
            ovf      <= 1'b0;
`endif
          end
        end
        ITER: begin
          acc <= sum;
`ifdef SERIES_SAT_EN
          ovf <= ovf | term_ovf | sum_ovf;
`endif
          if (rom_addr == '0) result   <= sum;
          else                rom_addr <= rom_addr - 1'b1;
        end
        DONE: rom_addr <= '0;
        default: ;
      endcase
    end
  end

  assign busy = (state == ITER) || (state == DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_series_rom_sequencer.sv
// Randomized self-checking bench for series_rom_sequencer against a plain-integer Horner model.
module tb_series_rom_sequencer;

  localparam int WIDTH   = 16;
  localparam int FRAC    = 10;
  localparam int N_TERMS = 7;
  localparam int ADDR_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  x;
  logic [ADDR_W-1:0] rom_addr;
  logic [WIDTH-1:0]  rom_data;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
`ifdef SERIES_SAT_EN
  logic              ovf;
`endif

  logic [WIDTH-1:0] rom_tbl [8];
  int total = 0;
  int bad   = 0;

  series_rom_sequencer #(
    .WIDTH(WIDTH), .FRAC(FRAC), .N_TERMS(N_TERMS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .x(x),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .done(done), .result(result)
`ifdef SERIES_SAT_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  always_comb rom_data = rom_tbl[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint reduce(input longint v, inout bit o);
`ifdef SERIES_SAT_EN
    if (v > 32767) begin o = 1'b1; return 32767; end
    if (v < -32768) begin o = 1'b1; return -32768; end
    return v;
`else
    o = o;
    return ((v % 65536) + 65536 + 32768) % 65536 - 32768;
`endif
  endfunction

  // Horner's rule on plain integers, with the reduction applied after shift and after add.
  function automatic void model(input logic [15:0] xv, output logic [15:0] r, output bit o);
    longint acc;
    longint t;
    acc = 0;
    o   = 1'b0;
    for (int k = N_TERMS - 1; k >= 0; k--) begin
      t   = (acc * longint'($signed(xv))) >>> FRAC;
      t   = reduce(t, o);
      t   = t + longint'($signed(rom_tbl[k]));
      acc = reduce(t, o);
    end
    r = acc[15:0];
  endfunction

  task automatic load_real_rom();
    rom_tbl[0] = 16'hFC00;  // -1024
    rom_tbl[1] = 16'hFF9C;  // -100
    rom_tbl[2] = 16'h0032;  //  50
    rom_tbl[3] = 16'hFFB0;  // -80
    rom_tbl[4] = 16'hFF9C;  // -100
    rom_tbl[5] = 16'hFFD6;  // -42
    rom_tbl[6] = 16'hFFCC;  // -52
    rom_tbl[7] = 16'h1234;  // never addressed with N_TERMS=7
  endtask

  // One evaluation; called shortly after a rising edge with the DUT idle.
  task automatic eval(input logic [15:0] xv, input bit poke, output logic [15:0] r_got);
    logic [15:0] r_exp;
    bit          o_exp;
    model(xv, r_exp, o_exp);
    start = 1'b1;
    x     = xv;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < N_TERMS; k++) begin
      check("iter_addr", rom_addr, N_TERMS - 1 - k);
      check("iter_busy", busy, 1);
      check("iter_done", done, 0);
      start = (poke && k == 2);
      x     = $urandom;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("result", result, r_exp);
`ifdef SERIES_SAT_EN
    check("ovf", ovf, o_exp);
`endif
    r_got = result;
    @(posedge clk); #1;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_addr", rom_addr, 0);
    check("result_held", result, r_exp);
  endtask

  initial begin
    logic [15:0] r;
    int          n_done;

    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    load_real_rom();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_addr", rom_addr, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    eval(16'h0000, 1'b0, r);
    check("x0_spec", r, 16'hFC00);
    eval(16'h0400, 1'b0, r);
    check("xp1_spec", r, 16'hFABC);
    eval(16'hFC00, 1'b1, r);
    check("xm1_spec", r, 16'hFC78);

    for (int i = 0; i < 8; i++) rom_tbl[i] = 16'h7FFF;
    eval(16'h0400, 1'b0, r);
`ifdef SERIES_SAT_EN
    check("const_sat", r, 16'h7FFF);
    check("const_ovf", ovf, 1);
`else
    check("const_wrap", r, 16'h7FF9);
`endif

    // Reset in cycle 4 of an evaluation; result held 0x7FFF/0x7FF9 beforehand.
    load_real_rom();
    start = 1'b1;
    x     = 16'h0400;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_addr", rom_addr, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    eval(16'h0000, 1'b0, r);
    check("post_rst_x0", r, 16'hFC00);

    // Start held high: back-to-back evaluations with x re-latched each time.
    start = 1'b1;
    x     = 16'h0000;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      check($sformatf("held_done_c%0d", i), done, (i == 8 || i == 17));
      if (i == 8 || i == 17) check("held_result", result, 16'hFC00);
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("held_drain_busy", busy, 0);

    // Random coefficient tables and operands.
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 8; i++) rom_tbl[i] = 16'($urandom);
      if (n < 4) for (int i = 0; i < 8; i++) rom_tbl[i] = 16'($signed(rom_tbl[i]) >>> 4);
      eval(16'($urandom), n[0], r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/series_rom_sequencer.md
Name: series_rom_sequencer

Overview:
Sequences the 8-entry 16-bit coefficient ROM. It evaluates a fixed-point polynomial by Horner's rule: acc = (acc*x >>> FRAC) + coef[k], for k stepping from N_TERMS-1 down to 0. The block drives the ROM address, consumes the ROM word in the same cycle (the ROM is combinational), and returns the Q-format result with a start/done handshake. It sits between the top-level control FSM and the ROM.

Parameters:
WIDTH, 16, data width of x, ROM word, accumulator and result (two's complement)
FRAC, 10, fractional bits of x and of the coefficients (Q5.10)
N_TERMS, 7, number of coefficients used, legal range 1..8
ADDR_W, 3, ROM address width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
start  in  1  request; sampled only in IDLE
x  in  WIDTH  operand, latched when start is accepted
rom_addr  out  ADDR_W  ROM select, registered
rom_data  in  WIDTH  ROM output, combinational from rom_addr
busy  out  1  high in ITER and DONE
done  out  1  one-cycle pulse when result is valid
result  out  WIDTH  final accumulator, held until the next accepted start

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, x_q=0, rom_addr=0, busy=0, done=0, result=0.
- States: IDLE, ITER, DONE.
- IDLE:
  - start=1 -> x_q<=x, acc<=0, rom_addr<=N_TERMS-1, go to ITER.
  - start=0 -> stay in IDLE.
- ITER, one term per cycle:
  - p = acc*x_q as a 2*WIDTH signed product.
  - t = p >>> FRAC (arithmetic shift), reduced to WIDTH bits (see SAT_EN).
  - s = t + rom_data in WIDTH+1 bits, reduced to WIDTH bits (see SAT_EN).
  - acc <= s.
  - If rom_addr==0: result <= s, go to DONE. Otherwise rom_addr <= rom_addr-1.
- DONE: done=1 for exactly this cycle, busy=1, rom_addr<=0, then go to IDLE.
- Latency: start sampled at edge 0; ITER occupies cycles 1..N_TERMS; done=1 in cycle N_TERMS+1. The next start can be accepted in cycle N_TERMS+2, giving a throughput of one evaluation per N_TERMS+2 cycles.
- Boundary cases:
  - start while busy: ignored, not queued.
  - start held high continuously: back-to-back evaluations, each with x re-latched in IDLE.
  - N_TERMS=1: a single ITER cycle; result = coef[0].
  - x and rom_data changing during ITER: x has no effect (x_q is used); rom_data must be valid in the same cycle as rom_addr.
  - rst mid-evaluation: immediate return to reset values; no done pulse; result cleared to 0.
- rom_addr never exceeds N_TERMS-1.

Optional Feature:
SERIES_SAT_EN
- Defined: each WIDTH reduction (shifted product and sum) saturates to the range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- An additional output port, ovf (1 bit), is present. It is sticky across an evaluation, is cleared when start is accepted, is valid alongside done, and resets to 0.
- Undefined: both reductions truncate to the low WIDTH bits (two's complement wrap), and the ovf port is absent.

Test Plan:
- Real ROM attached, x=0, start pulse -> rom_addr sequence 6,5,4,3,2,1,0; done in cycle 8; result=0xFC00 (-1024).
- Real ROM, x=0x0400 (+1.0) -> result=0xFABC (-1348), the sum of all coefficients; busy high for cycles 1..8.
- Real ROM, x=0xFC00 (-1.0) -> result=0xFC78 (-904); start pulsed again during cycle 3 is ignored, giving exactly one done pulse.
- Bench drives rom_data=0x7FFF constantly, x=0x0400:
  - SERIES_SAT_EN defined -> result=0x7FFF, ovf=1.
  - SERIES_SAT_EN undefined -> result=0x7FF9.
- rst asserted asynchronously in cycle 4 of an evaluation -> busy, done, result and rom_addr go to 0 immediately; no done pulse. A fresh start with x=0 then yields 0xFC00 with normal latency.
- start held high for 20 cycles with x=0 -> done pulses in cycles 8 and 17, each with result 0xFC00.
